// File: rtl/pulse_seq_multi.sv
// N-channel pulse-train sequencer with scope sync, receiver blocking window and attenuator
// control. Settings are double-buffered and become active only at the period wrap.
module pulse_seq_multi #(
    parameter int NCH     = 4,
    parameter int CW      = 32,
    parameter int TW      = 16,
    parameter int RW      = 8,
    parameter int AW      = 7,
    parameter int ATT_OFF = 6,
    parameter int PER_RST = 10000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CW-1:0]     per,
    input  logic [NCH*TW-1:0] ch_start,
    input  logic [NCH*TW-1:0] ch_width,
    input  logic [NCH*TW-1:0] ch_space,
    input  logic [NCH*RW-1:0] ch_rep,
    input  logic [TW-1:0]     sync_len,
    input  logic [TW-1:0]     blk_gap,
    input  logic [TW-1:0]     blk_len,
    input  logic              bl_en,
    input  logic              cw_mode,
    input  logic [AW-1:0]     pr_att,
    input  logic              load,
    output logic              frame_start,
    output logic [NCH-1:0]    ch_out,
    output logic              sync_out,
    output logic              block_out,
    output logic [AW-1:0]     att_out,
    output logic              pending
);
    localparam int EW  = CW + 1;
    localparam int AW1 = AW + 1;

    typedef enum logic [2:0] {IDLE, WAIT, HIGH, GAP, DONE} ch_state_t;

    // Edge values are one bit wider than the counter; all-ones can never equal a count.
    function automatic logic [EW-1:0] sat_add(input logic [EW-1:0] a, input logic [EW-1:0] b);
        logic [EW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[EW] ? '1 : s[EW-1:0];
    endfunction

    function automatic logic [AW-1:0] att_sat(input logic [AW-1:0] a);
        logic [AW:0] s;
        s = {1'b0, a} + AW1'(ATT_OFF);
        return s[AW] ? '1 : s[AW-1:0];
    endfunction

    logic [CW-1:0]     sh_per, ac_per;
    logic [NCH*TW-1:0] sh_start, sh_width, sh_space, ac_start, ac_width, ac_space;
    logic [NCH*RW-1:0] sh_rep, ac_rep;
    logic [TW-1:0]     sh_sync, sh_gap, sh_len, ac_sync, ac_gap, ac_len;
    logic              sh_bl, sh_cw, ac_bl, ac_cw;
    logic [AW-1:0]     sh_att, ac_att;

    logic [CW-1:0] cnt_p0;
    logic [EW-1:0] c_x;
    logic          wrap, apply;

    assign wrap  = (cnt_p0 == ac_per - CW'(1));
    assign apply = wrap & pending;
    assign c_x   = {1'b0, cnt_p0};

    always_ff @(posedge clk) begin
        if (load) begin
            sh_per   <= (per < CW'(2)) ? CW'(2) : per;
            sh_start <= ch_start;
            sh_width <= ch_width;
            sh_space <= ch_space;
            sh_rep   <= ch_rep;
            sh_sync  <= sync_len;
            sh_gap   <= blk_gap;
            sh_len   <= blk_len;
            sh_bl    <= bl_en;
            sh_cw    <= cw_mode;
            sh_att   <= pr_att;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ac_per  <= CW'(PER_RST);
            ac_rep  <= '0;
            ac_sync <= '0;
            ac_bl   <= 1'b0;
            ac_cw   <= 1'b0;
            ac_att  <= pr_att;
            pending <= 1'b0;
            cnt_p0  <= '0;
        end else begin
            if (apply) begin
                ac_per   <= sh_per;
                ac_start <= sh_start;
                ac_width <= sh_width;
                ac_space <= sh_space;
                ac_rep   <= sh_rep;
                ac_sync  <= sh_sync;
                ac_gap   <= sh_gap;
                ac_len   <= sh_len;
                ac_bl    <= sh_bl;
                ac_cw    <= sh_cw;
                ac_att   <= sh_att;
            end
            pending <= load | (pending & ~wrap);
            cnt_p0  <= wrap ? '0 : cnt_p0 + CW'(1);
        end
    end

    // ---- stage p0 -> p1: per-channel pulse FSMs evaluated for counter value cnt_p0
    logic [NCH-1:0] hi_p1;
    logic [EW-1:0]  ee0_p1;
    logic [RW-1:0]  n0_p1;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        ch_state_t     st_p1, st_n;
        logic [EW-1:0] ns_p1, ns_n, ee_p1, ee_n;
        logic [RW-1:0] n_p1, n_n, rep_k;
        logic [EW-1:0] start_x, width_x, space_x;

        assign rep_k   = ac_rep[k*RW +: RW];
        assign start_x = EW'(ac_start[k*TW +: TW]);
        assign width_x = EW'(ac_width[k*TW +: TW]);
        assign space_x = EW'(ac_space[k*TW +: TW]);

        always_comb begin
            st_n = st_p1;
            ns_n = ns_p1;
            ee_n = ee_p1;
            n_n  = n_p1;
            if (cnt_p0 == '0) begin
                ns_n = start_x;
                ee_n = '1;
                n_n  = '0;
                st_n = (rep_k == '0 || width_x == '0) ? DONE : WAIT;
            end
            if (st_n == HIGH && c_x == ee_n)
                st_n = (n_n == rep_k) ? DONE : GAP;
            // A start coinciding with an end wins, so overlapping pulses merge without a gap.
            if ((st_n == WAIT || st_n == GAP || st_n == HIGH) && n_n != rep_k && c_x == ns_n) begin
                st_n = HIGH;
                ee_n = sat_add(ns_n, width_x);
                ns_n = sat_add(ns_n, space_x);
                n_n  = (space_x == '0) ? rep_k : n_n + RW'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (reset) st_p1 <= IDLE;
            else       st_p1 <= st_n;
            ns_p1 <= ns_n;
            ee_p1 <= ee_n;
            n_p1  <= n_n;
        end

        assign hi_p1[k] = (st_p1 == HIGH);

        if (k == 0) begin : g_ch0
            assign ee0_p1 = ee_p1;
            assign n0_p1  = n_p1;
        end
    end

    // Blocking window: armed each period, latched once channel 0 has issued its last pulse.
    logic [EW-1:0] ws_p1, ws_n, we_p1, we_n;
    logic          bopen_p1, bopen_n, arm_p1, arm_n;

    always_comb begin
        ws_n    = ws_p1;
        we_n    = we_p1;
        bopen_n = bopen_p1;
        arm_n   = arm_p1;
        if (cnt_p0 == '0) begin
            ws_n    = '1;
            we_n    = '1;
            bopen_n = 1'b0;
            arm_n   = 1'b1;
        end else if (arm_p1 && hi_p1[0] && n0_p1 == ac_rep[RW-1:0]) begin
            ws_n  = sat_add(ee0_p1, EW'(ac_gap));
            we_n  = sat_add(ws_n, EW'(ac_len));
            arm_n = 1'b0;
        end
        if (c_x == ws_n) bopen_n = 1'b1;
        if (c_x == we_n) bopen_n = 1'b0;
    end

    logic          vld_p1, sync_p1, frame_p1, cw_p1, bl_p1;
    logic [AW-1:0] att_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1   <= 1'b0;
            bopen_p1 <= 1'b0;
            arm_p1   <= 1'b0;
        end else begin
            vld_p1   <= 1'b1;
            bopen_p1 <= bopen_n;
            arm_p1   <= arm_n;
        end
        ws_p1    <= ws_n;
        we_p1    <= we_n;
        sync_p1  <= (c_x < EW'(ac_sync));
        frame_p1 <= (cnt_p0 == '0);
        cw_p1    <= ac_cw;
        bl_p1    <= ac_bl;
        att_p1   <= ac_att;
    end

    // ---- stage p1 -> p2: output registers
    always_ff @(posedge clk) begin
        if (reset || !vld_p1) begin
            frame_start <= 1'b0;
            ch_out      <= '0;
            sync_out    <= 1'b0;
            block_out   <= 1'b1;
            att_out     <= pr_att;
        end else begin
            frame_start <= frame_p1;
            sync_out    <= sync_p1;
            if (cw_p1) begin
                ch_out    <= NCH'(1);
                block_out <= 1'b0;
                att_out   <= att_p1;
            end else begin
                ch_out    <= hi_p1;
                block_out <= ~(bl_p1 & bopen_p1);
                att_out   <= (|hi_p1) ? att_sat(att_p1) : att_p1;
            end
        end
    end
endmodule

// File: tb/tb_pulse_seq_multi.sv
// Directed self-checking bench for pulse_seq_multi: each period is compared cycle by cycle
// against a closed-form pulse model of the configuration expected to be active.
module tb_pulse_seq_multi;
    localparam int NCH = 4;
    localparam int CW  = 32;
    localparam int TW  = 16;
    localparam int RW  = 8;
    localparam int AW  = 7;

    logic              clk, reset, load;
    logic [CW-1:0]     per;
    logic [NCH*TW-1:0] ch_start, ch_width, ch_space;
    logic [NCH*RW-1:0] ch_rep;
    logic [TW-1:0]     sync_len, blk_gap, blk_len;
    logic              bl_en, cw_mode;
    logic [AW-1:0]     pr_att;
    logic              frame_start, sync_out, block_out, pending;
    logic [NCH-1:0]    ch_out;
    logic [AW-1:0]     att_out;

    int cfg_start[NCH], cfg_width[NCH], cfg_space[NCH], cfg_rep[NCH];
    int cfg_per, cfg_sync, cfg_gap, cfg_len, cfg_bl, cfg_cw, cfg_att;
    int mdl_start[NCH], mdl_width[NCH], mdl_space[NCH], mdl_rep[NCH];
    int mdl_per, mdl_sync, mdl_gap, mdl_len, mdl_bl, mdl_cw, mdl_att;
    int n_assert = 0;
    int n_fail   = 0;

    pulse_seq_multi dut (
        .clk(clk), .reset(reset), .per(per), .ch_start(ch_start), .ch_width(ch_width),
        .ch_space(ch_space), .ch_rep(ch_rep), .sync_len(sync_len), .blk_gap(blk_gap),
        .blk_len(blk_len), .bl_en(bl_en), .cw_mode(cw_mode), .pr_att(pr_att), .load(load),
        .frame_start(frame_start), .ch_out(ch_out), .sync_out(sync_out),
        .block_out(block_out), .att_out(att_out), .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        ch_start = '0;
        ch_width = '0;
        ch_space = '0;
        ch_rep   = '0;
        for (int k = 0; k < NCH; k++) begin
            ch_start[k*TW +: TW] = TW'(cfg_start[k]);
            ch_width[k*TW +: TW] = TW'(cfg_width[k]);
            ch_space[k*TW +: TW] = TW'(cfg_space[k]);
            ch_rep[k*RW +: RW]   = RW'(cfg_rep[k]);
        end
        per      = CW'(cfg_per);
        sync_len = TW'(cfg_sync);
        blk_gap  = TW'(cfg_gap);
        blk_len  = TW'(cfg_len);
        bl_en    = (cfg_bl != 0);
        cw_mode  = (cfg_cw != 0);
        pr_att   = AW'(cfg_att);
    end

    task automatic check(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s c=%0d observed=%0h expected=%0h", tag, c, obs, exp);
        end
    endtask

    function automatic logic [NCH-1:0] raw_hi(input int c);
        logic [NCH-1:0] r;
        longint s;
        r = '0;
        for (int k = 0; k < NCH; k++)
            for (int i = 0; i < mdl_rep[k]; i++) begin
                s = longint'(mdl_start[k]) + longint'(i) * longint'(mdl_space[k]);
                if (c >= s && c < s + mdl_width[k]) r[k] = 1'b1;
            end
        return r;
    endfunction

    function automatic logic exp_block(input int c);
        longint e;
        if (mdl_cw != 0) return 1'b0;
        if (mdl_bl == 0 || mdl_rep[0] == 0 || mdl_width[0] == 0) return 1'b1;
        e = longint'(mdl_start[0]) + longint'(mdl_rep[0] - 1) * mdl_space[0] + mdl_width[0] + mdl_gap;
        return (c >= e && c < e + mdl_len) ? 1'b0 : 1'b1;
    endfunction

    function automatic int exp_att(input int c);
        if (mdl_cw != 0 || raw_hi(c) == '0) return mdl_att;
        return (mdl_att + 6 > 127) ? 127 : mdl_att + 6;
    endfunction

    task automatic check_period(input int first, input int last);
        logic [NCH-1:0] e_ch;
        for (int c = first; c <= last; c++) begin
            e_ch = (mdl_cw != 0) ? NCH'(1) : raw_hi(c);
            check("ch_out", c, ch_out, e_ch);
            check("sync_out", c, sync_out, (c < mdl_sync) ? 1 : 0);
            check("frame_start", c, frame_start, (c == 0) ? 1 : 0);
            check("block_out", c, block_out, exp_block(c));
            check("att_out", c, att_out, exp_att(c));
            @(negedge clk);
        end
    endtask

    task automatic check_reset_vals(input int c);
        check("rst_ch_out", c, ch_out, 0);
        check("rst_sync", c, sync_out, 0);
        check("rst_frame", c, frame_start, 0);
        check("rst_block", c, block_out, 1);
        check("rst_att", c, att_out, cfg_att);
        check("rst_pending", c, pending, 0);
    endtask

    task automatic clear_chans();
        for (int k = 0; k < NCH; k++) begin
            cfg_start[k] = 0; cfg_width[k] = 0; cfg_space[k] = 0; cfg_rep[k] = 0;
        end
        cfg_gap = 0; cfg_len = 0; cfg_bl = 0; cfg_cw = 0;
    endtask

    task automatic set_ch(input int k, input int s, input int w, input int sp, input int r);
        cfg_start[k] = s; cfg_width[k] = w; cfg_space[k] = sp; cfg_rep[k] = r;
    endtask

    task automatic apply_model();
        for (int k = 0; k < NCH; k++) begin
            mdl_start[k] = cfg_start[k]; mdl_width[k] = cfg_width[k];
            mdl_space[k] = cfg_space[k]; mdl_rep[k]   = cfg_rep[k];
        end
        mdl_per = cfg_per; mdl_sync = cfg_sync; mdl_gap = cfg_gap; mdl_len = cfg_len;
        mdl_bl = cfg_bl; mdl_cw = cfg_cw; mdl_att = cfg_att;
    endtask

    task automatic do_load();
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_frame(input int budget);
        int n;
        n = 0;
        while (frame_start !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("frame_wait", 0, frame_start, 1);
    endtask

    // Called at output cycle 0: load mid-period, old settings finish the period, new ones follow.
    task automatic step_cfg();
        int pold;
        pold = mdl_per;
        do_load();
        check("pending_set", 1, pending, 1);
        check_period(1, pold - 1);
        apply_model();
        check("pending_clear", 0, pending, 0);
        check_period(0, mdl_per - 1);
    endtask

    initial begin
        reset = 1'b1;
        load  = 1'b0;
        clear_chans();
        cfg_per = 100; cfg_sync = 0; cfg_att = 20;
        apply_model();
        mdl_per = 10000;
        repeat (3) @(negedge clk);
        check_reset_vals(-1);
        reset = 1'b0;
        @(negedge clk);
        check("first_frame_early", -1, frame_start, 0);
        @(negedge clk);
        check("first_frame", 0, frame_start, 1);

        // single pulse, period 100, applied at the first wrap of the reset period
        set_ch(0, 5, 3, 0, 1);
        cfg_sync = 8;
        do_load();
        check("pending_set", 1, pending, 1);
        wait_frame(10100);
        apply_model();
        check("pending_clear", 0, pending, 0);
        check_period(0, 99);

        // three-pulse train on channel 1
        clear_chans();
        set_ch(1, 10, 4, 20, 3);
        step_cfg();

        // overlapping pulses merge into one
        clear_chans();
        set_ch(0, 0, 10, 5, 3);
        step_cfg();

        // shorter period truncates, edge beyond the period never fires, saturated attenuator
        clear_chans();
        cfg_per = 50; cfg_sync = 60; cfg_att = 124;
        set_ch(2, 45, 20, 15, 2);
        step_cfg();

        // width change loaded mid-period
        clear_chans();
        cfg_sync = 8; cfg_att = 20;
        set_ch(0, 2, 3, 0, 1);
        step_cfg();
        cfg_width[0] = 7;
        step_cfg();

        // load in the wrap cycle applies one period later
        cfg_width[0] = 5;
        check_period(0, 46);
        do_load();
        check("pending_wrap_set", 48, pending, 1);
        check_period(48, 49);
        check_period(0, 24);
        check("pending_held", 25, pending, 1);
        check_period(25, 49);
        apply_model();
        check("pending_wrap_clear", 0, pending, 0);
        check_period(0, 49);

        // CW mode
        clear_chans();
        set_ch(1, 10, 4, 0, 1);
        cfg_cw = 1;
        step_cfg();

        // blocking window after channel 0's last pulse, then reset mid-period
        clear_chans();
        cfg_bl = 1; cfg_gap = 3; cfg_len = 5;
        set_ch(0, 0, 4, 10, 2);
        step_cfg();
        check_period(0, 11);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals(13);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
